// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache miss
// handler and the D-cache miss / store write-through path. A miss issues a
// full block of pipelined word reads and steers the returning beats into the
// owning cache's fill port; a store is written through in a single cycle.
module mem_arbiter #(
  parameter int WORDS = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_miss,
  input  logic [15:0]      i_miss_addr,
  input  logic             d_miss,
  input  logic [15:0]      d_miss_addr,
  input  logic             d_wr_req,
  input  logic [15:0]      d_wr_addr,
  input  logic [15:0]      d_wr_data,
  output logic             d_wr_ack,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_data_valid,
  output logic             i_fill_we,
  output logic             d_fill_we,
  output logic [IDX_W-1:0] fill_word,
  output logic [15:0]      fill_data,
  output logic             i_fill_done,
  output logic             d_fill_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } state_t;

  // Block is 2*WORDS bytes; the mask clears the byte offset within a block.
  localparam logic [15:0]    BLOCK_MASK = ~16'((2 * WORDS) - 1);
  localparam logic [IDX_W:0] WORDS_C    = (IDX_W + 1)'(WORDS);
  localparam logic [IDX_W:0] LAST_C     = (IDX_W + 1)'(WORDS - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [15:0]      r_base;
  logic [15:0]      r_wrAddr;
  logic [15:0]      r_wrData;
  logic [IDX_W:0]   r_issueCnt;
  logic [IDX_W:0]   r_recvCnt;
  logic [15:0]      w_offset;
  logic             w_issuing;
  logic             w_lastBeat;
  logic             w_issue;
  logic             w_beat;

  // Word offset of the next read: two bytes per issued word.
  assign w_offset   = {{(16 - IDX_W - 2){1'b0}}, r_issueCnt, 1'b0};
  assign w_issuing  = (r_issueCnt < WORDS_C);
  assign w_lastBeat = (r_recvCnt == LAST_C);

  assign fill_word  = r_recvCnt[IDX_W-1:0];
  assign fill_data  = mem_rdata;
  assign busy       = (r_state != IDLE);

  // State register; reset forces IDLE from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection with fixed grant priority and per-state port drive.
  always_comb begin
    w_nextState = r_state;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 16'h0000;
    d_wr_ack    = 1'b0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    w_issue     = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_wr_req) begin
          w_nextState = WRITE;
        end else if (d_miss) begin
          w_nextState = FILL_D;
        end else if (i_miss) begin
          w_nextState = FILL_I;
        end
      end
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_wrAddr;
        mem_wdata   = r_wrData;
        d_wr_ack    = 1'b1;
        w_nextState = IDLE;
      end
      FILL_I: begin
        if (w_issuing) begin
          mem_en   = 1'b1;
          mem_addr = r_base + w_offset;
          w_issue  = 1'b1;
        end
        if (mem_data_valid) begin
          i_fill_we = 1'b1;
          w_beat    = 1'b1;
          if (w_lastBeat) begin
            i_fill_done = 1'b1;
            w_nextState = IDLE;
          end
        end
      end
      FILL_D: begin
        if (w_issuing) begin
          mem_en   = 1'b1;
          mem_addr = r_base + w_offset;
          w_issue  = 1'b1;
        end
        if (mem_data_valid) begin
          d_fill_we = 1'b1;
          w_beat    = 1'b1;
          if (w_lastBeat) begin
            d_fill_done = 1'b1;
            w_nextState = IDLE;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Latch the granted request's address/data and step the issue/receive counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= 16'h0000;
      r_wrAddr   <= 16'h0000;
      r_wrData   <= 16'h0000;
      r_issueCnt <= '0;
      r_recvCnt  <= '0;
    end else if (r_state == IDLE) begin
      if (d_wr_req) begin
        r_wrAddr <= d_wr_addr;
        r_wrData <= d_wr_data;
      end else if (d_miss) begin
        r_base     <= d_miss_addr & BLOCK_MASK;
        r_issueCnt <= '0;
        r_recvCnt  <= '0;
      end else if (i_miss) begin
        r_base     <= i_miss_addr & BLOCK_MASK;
        r_issueCnt <= '0;
        r_recvCnt  <= '0;
      end
    end else begin
      if (w_issue) begin
        r_issueCnt <= r_issueCnt + 1'b1;
      end
      if (w_beat) begin
        r_recvCnt <= r_recvCnt + 1'b1;
      end
    end
  end

endmodule
